phase_addsub_pipe: RTL and testbench

PHASE_ADDSUB_PIPE -- requirements
Module: phase_addsub_pipe

---
 rtl/phase_addsub_pipe.sv | 159 +++++++++++++++
 tb/tb_phase_addsub_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_addsub_pipe.sv
// rtl/phase_addsub_pipe.sv - phase-scheduled two-stage add/sub pipeline (optional PHASE_ADDSUB_SAT_EN saturation)
module phase_addsub_pipe #(
    parameter int WIDTH   = 16,
    parameter int N_PHASE = 256,
    parameter int ADD_LO  = 144,
    parameter int ADD_HI  = 144
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic [1:0]                   op_mode,
    input  logic [WIDTH-1:0]             dina,
    input  logic [WIDTH-1:0]             dinb,
    output logic [WIDTH-1:0]             dout,
    output logic                         out_valid,
    output logic                         ovf,
    output logic [$clog2(N_PHASE)-1:0]   phase_idx
);

    localparam int IDX_W = $clog2(N_PHASE);

    localparam logic [1:0] MODE_SCHED = 2'b00;
    localparam logic [1:0] MODE_ADD   = 2'b01;
    localparam logic [1:0] MODE_SUB   = 2'b10;
    localparam logic [1:0] MODE_PASS  = 2'b11;

    localparam logic [N_PHASE-1:0] RING_RST = N_PHASE'(1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_PHASE - 1);

    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // phase ring and its binary index
    logic [N_PHASE-1:0] ring_q, ring_d;
    logic [IDX_W-1:0]   phase_idx_q, phase_idx_d;

    // stage-1 operand registers
    logic [WIDTH-1:0]   s1_a_q, s1_a_d;
    logic [WIDTH-1:0]   s1_b_q, s1_b_d;
    logic [1:0]         s1_mode_q, s1_mode_d;
    logic               s1_valid_q, s1_valid_d;
    logic               s1_add_sel_q, s1_add_sel_d;

    // stage-2 result registers
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    // stage-2 combinational intermediates
    logic               do_add;
    logic [WIDTH-1:0]   arith;
    logic               arith_ovf;
    logic [WIDTH-1:0]   arith_res;

    // Ring rotates left when enabled; the binary index advances in lockstep so it never lags the ring
    always_comb begin
        ring_d      = ring_q;
        phase_idx_d = phase_idx_q;
        if (en) begin
            ring_d      = {ring_q[N_PHASE-2:0], ring_q[N_PHASE-1]};
            phase_idx_d = (phase_idx_q == LAST_IDX) ? '0 : phase_idx_q + IDX_W'(1);
        end
    end

    // Stage 1 captures operands every cycle; add_sel comes from the pre-advance ring
    always_comb begin
        s1_a_d       = dina;
        s1_b_d       = dinb;
        s1_mode_d    = op_mode;
        s1_valid_d   = in_valid;
        s1_add_sel_d = |ring_q[ADD_HI:ADD_LO];
    end

    // Stage 2 selects the operation, detects signed overflow and holds results on idle cycles
    always_comb begin
        dout_d      = dout_q;
        ovf_d       = ovf_q;
        out_valid_d = s1_valid_q;
        do_add      = 1'b0;
        arith       = '0;
        arith_ovf   = 1'b0;
        arith_res   = '0;

        case (s1_mode_q)
            MODE_SCHED: do_add = s1_add_sel_q;
            MODE_ADD:   do_add = 1'b1;
            default:    do_add = 1'b0;
        endcase

        if (do_add) begin
            arith     = s1_a_q + s1_b_q;
            arith_ovf = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                        (arith[WIDTH-1] != s1_a_q[WIDTH-1]);
        end else begin
            arith     = s1_a_q - s1_b_q;
            arith_ovf = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                        (arith[WIDTH-1] != s1_a_q[WIDTH-1]);
        end

`ifdef PHASE_ADDSUB_SAT_EN
        // on overflow the true result always has the sign of operand a
        if (arith_ovf) begin
            arith_res = s1_a_q[WIDTH-1] ? NEG_MIN : POS_MAX;
        end else begin
            arith_res = arith;
        end
`else
        arith_res = arith;
`endif

        if (s1_valid_q) begin
            if (s1_mode_q == MODE_PASS) begin
                dout_d = s1_a_q;
                ovf_d  = 1'b0;
            end else begin
                dout_d = arith_res;
                ovf_d  = arith_ovf;
            end
        end
    end

    // All state registers; reset wins over enable and discards in-flight operations
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_q       <= RING_RST;
            phase_idx_q  <= '0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_mode_q    <= 2'b00;
            s1_valid_q   <= 1'b0;
            s1_add_sel_q <= 1'b0;
            dout_q       <= '0;
            ovf_q        <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            ring_q       <= ring_d;
            phase_idx_q  <= phase_idx_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_mode_q    <= s1_mode_d;
            s1_valid_q   <= s1_valid_d;
            s1_add_sel_q <= s1_add_sel_d;
            dout_q       <= dout_d;
            ovf_q        <= ovf_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign dout      = dout_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;
    assign phase_idx = phase_idx_q;

    // constants kept for readability of the mode decode
    logic unused_mode_const;
    assign unused_mode_const = ^{MODE_SUB, POS_MAX, NEG_MIN};

endmodule

// File: tb/tb_phase_addsub_pipe.sv
// tb/tb_phase_addsub_pipe.sv - randomized bench for phase_addsub_pipe against a behavioural model
module tb_phase_addsub_pipe;

    localparam int W     = 16;
    localparam int NP    = 256;
    localparam int LO    = 144;
    localparam int HI    = 144;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          in_valid;
    logic [1:0]    op_mode;
    logic [W-1:0]  dina, dinb;
    logic [W-1:0]  dout;
    logic          out_valid, ovf;
    logic [7:0]    phase_idx;

    logic [7:0]    dina8, dinb8, dout8;
    logic          out_valid8, ovf8;
    logic [1:0]    phase_idx8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    phase_addsub_pipe #(.WIDTH(W), .N_PHASE(NP), .ADD_LO(LO), .ADD_HI(HI)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .op_mode(op_mode),
        .dina(dina), .dinb(dinb), .dout(dout), .out_valid(out_valid), .ovf(ovf),
        .phase_idx(phase_idx)
    );

    phase_addsub_pipe #(.WIDTH(8), .N_PHASE(4), .ADD_LO(1), .ADD_HI(2)) dut8 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .op_mode(op_mode),
        .dina(dina8), .dinb(dinb8), .dout(dout8), .out_valid(out_valid8), .ovf(ovf8),
        .phase_idx(phase_idx8)
    );

    typedef struct {
        logic         valid;
        logic [W-1:0] res;
        logic         ovf;
    } txn_t;

    txn_t         pipe[$];
    int           m_phase;
    logic [W-1:0] m_dout;
    logic         m_ovf;
    logic         m_valid;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // exact signed arithmetic, then range check, then wrap or clamp
    task automatic compute(input logic [1:0] mode, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit in_window, output logic [W-1:0] res, output logic ov);
        longint sa, sb, exact;
        bit     add;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (mode == 2'b11) begin
            res = a;
            ov  = 1'b0;
        end else begin
            add   = (mode == 2'b01) || (mode == 2'b00 && in_window);
            exact = add ? sa + sb : sa - sb;
            ov    = (exact > 32767) || (exact < -32768);
`ifdef PHASE_ADDSUB_SAT_EN
            if (ov) res = (exact > 0) ? 16'h7fff : 16'h8000;
            else    res = exact[W-1:0];
`else
            res = exact[W-1:0];
`endif
        end
    endtask

    task automatic model_edge();
        txn_t t, o;
        if (rst) begin
            m_phase = 0;
            pipe.delete();
            t.valid = 1'b0; t.res = '0; t.ovf = 1'b0;
            pipe.push_back(t);
            m_dout = '0; m_ovf = 1'b0; m_valid = 1'b0;
        end else begin
            t.valid = in_valid;
            compute(op_mode, dina, dinb, (m_phase >= LO && m_phase <= HI), t.res, t.ovf);
            pipe.push_back(t);
            o = pipe.pop_front();
            m_valid = o.valid;
            if (o.valid) begin
                m_dout = o.res;
                m_ovf  = o.ovf;
            end
            if (en) m_phase = (m_phase + 1) % NP;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("phase_idx", 64'(phase_idx), 64'(m_phase));
        check_eq("out_valid", 64'(out_valid), 64'(m_valid));
        check_eq("dout", 64'(dout), 64'(m_dout));
        check_eq("ovf", 64'(ovf), 64'(m_ovf));
        check_eq("ring_onehot", 64'($onehot(dut.ring_q)), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin : main
        int cnt130, cnt_valid;
        logic [W-1:0] la, lb;
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; op_mode = 2'b00;
        dina = '0; dinb = '0; dina8 = '0; dinb8 = '0;
        m_phase = 0; m_dout = '0; m_ovf = 1'b0; m_valid = 1'b0;
        begin txn_t z; z.valid = 1'b0; z.res = '0; z.ovf = 1'b0; pipe.push_back(z); end

        // reset state
        do_reset();
        check_eq("rst_dout", 64'(dout), 64'd0);
        check_eq("rst_phase", 64'(phase_idx), 64'd0);

        // ring wrap over one full revolution
        en = 1'b1;
        for (int i = 0; i < NP; i++) step();
        check_eq("wrap_phase0", 64'(phase_idx), 64'd0);

        // default scheduled run: one add per revolution, subtract elsewhere
        do_reset();
        en = 1'b1; op_mode = 2'b00; dina = 16'd100; dinb = 16'd30; in_valid = 1'b1;
        step();
        check_eq("ov_lat1", 64'(out_valid), 64'd0);
        step();
        check_eq("ov_lat2", 64'(out_valid), 64'd1);
        cnt130 = (dout == 16'd130) ? 1 : 0;
        for (int i = 1; i < NP; i++) begin
            step();
            if (dout == 16'd130) cnt130++;
            else check_eq("sched_sub", 64'(dout), 64'd70);
        end
        check_eq("sched_add_count", 64'(cnt130), 64'd1);

        // frozen phase at the add slot
        do_reset();
        en = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < LO; i++) step();
        en = 1'b0; in_valid = 1'b1; op_mode = 2'b00;
        la = '0; lb = '0;
        for (int i = 0; i < 12; i++) begin
            la = W'($urandom_range(0, 1000));
            lb = W'($urandom_range(0, 1000));
            dina = la; dinb = lb;
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        check_eq("frozen_phase", 64'(phase_idx), 64'(LO));
        check_eq("frozen_add", 64'(dout), 64'(W'(la + lb)));

        // reset mid-stream discards the in-flight operation
        do_reset();
        in_valid = 1'b1; op_mode = 2'b01; dina = 16'd5; dinb = 16'd6; en = 1'b1;
        step();
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        check_eq("midrst_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_dout", 64'(dout), 64'd0);
        step();
        check_eq("midrst_valid2", 64'(out_valid), 64'd0);

        // pass-through with a gap in valid
        do_reset();
        op_mode = 2'b11; dina = 16'h1234; dinb = 16'hffff; in_valid = 1'b1;
        step();
        in_valid = 1'b0; dina = 16'h0bad;
        cnt_valid = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid) cnt_valid++;
        end
        check_eq("gap_dout", 64'(dout), 64'h1234);
        check_eq("gap_valid_count", 64'(cnt_valid), 64'd1);

        // 8-bit instance overflow corners
        do_reset();
        in_valid = 1'b1; op_mode = 2'b01; dina8 = 8'd127; dinb8 = 8'd1;
        step(); step();
`ifdef PHASE_ADDSUB_SAT_EN
        check_eq("w8_pos_ovf", 64'(dout8), 64'h7f);
`else
        check_eq("w8_pos_ovf", 64'(dout8), 64'h80);
`endif
        check_eq("w8_pos_ovf_flag", 64'(ovf8), 64'd1);
        op_mode = 2'b10; dina8 = 8'h80; dinb8 = 8'd1;
        step(); step();
`ifdef PHASE_ADDSUB_SAT_EN
        check_eq("w8_neg_ovf", 64'(dout8), 64'h80);
`else
        check_eq("w8_neg_ovf", 64'(dout8), 64'h7f);
`endif
        check_eq("w8_neg_ovf_flag", 64'(ovf8), 64'd1);
        op_mode = 2'b01; dina8 = 8'd5; dinb8 = 8'hfd;
        step(); step();
        check_eq("w8_plain", 64'(dout8), 64'd2);
        check_eq("w8_plain_flag", 64'(ovf8), 64'd0);
        check_eq("w8_valid", 64'(out_valid8), 64'd1);

        // randomized traffic with overflow-prone operands and sporadic reset
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            en       = ($urandom_range(0, 3) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            op_mode  = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       dina = 16'h7ff0 + W'($urandom_range(0, 15));
                1:       dina = 16'h8000 + W'($urandom_range(0, 15));
                default: dina = W'($urandom);
            endcase
            dinb = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 64)) : W'($urandom);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
